// File: rtl/mux_arbiter.sv
// mux_arbiter: two-requester round-robin arbiter that owns the select line of
// a shared 2:1 data mux. A hold counter forces rotation after MAX_HOLD
// consecutive grants while the other side is waiting. The selected word is
// registered together with a valid flag.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | nobody owns the mux, sel keeps its last value
// GRANT_A | requester A owns the mux, sel = 0 (data_a)
// GRANT_B | requester B owns the mux, sel = 1 (data_b)
module mux_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] outp,
  output logic             out_valid
);

  // A one-bit counter is kept even for MAX_HOLD = 1 so the width never collapses to zero.
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;    // 0: A granted last, 1: B granted last
  logic [HW-1:0]    hold_q, hold_d;
  logic             sel_q, sel_d;
  logic [WIDTH-1:0] outp_q, outp_d;
  logic             valid_q, valid_d;

  // State register and registered datapath outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      hold_q  <= '0;
      sel_q   <= 1'b0;
      outp_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      sel_q   <= sel_d;
      outp_q  <= outp_d;
      valid_q <= valid_d;
    end
  end

  // Next-state, hold counter, select and data capture.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    sel_d   = sel_q;
    outp_d  = outp_q;

    // Capture uses the current request level so a releasing side gets no valid word.
    valid_d = ((state_q == GRANT_A) && req_a) || ((state_q == GRANT_B) && req_b);
    if (valid_d) begin
      outp_d = (state_q == GRANT_B) ? data_b : data_a;
    end

    case (state_q)
      IDLE: begin
        if (req_a && req_b) begin
          state_d = last_q ? GRANT_A : GRANT_B;
        end else if (req_a) begin
          state_d = GRANT_A;
        end else if (req_b) begin
          state_d = GRANT_B;
        end
      end
      GRANT_A: begin
        if (!req_a) begin
          state_d = req_b ? GRANT_B : IDLE;
        end else if (req_b && (hold_q == HOLD_LAST)) begin
          state_d = GRANT_B;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + HW'(1);
        end
      end
      GRANT_B: begin
        if (!req_b) begin
          state_d = req_a ? GRANT_A : IDLE;
        end else if (req_a && (hold_q == HOLD_LAST)) begin
          state_d = GRANT_A;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Entering a grant state restarts the hold window and records the owner.
    if (state_d != state_q) begin
      if (state_d == GRANT_A) begin
        hold_d = '0;
        last_d = 1'b0;
        sel_d  = 1'b0;
      end else if (state_d == GRANT_B) begin
        hold_d = '0;
        last_d = 1'b1;
        sel_d  = 1'b1;
      end
    end
  end

  assign gnt_a     = (state_q == GRANT_A);
  assign gnt_b     = (state_q == GRANT_B);
  assign sel       = sel_q;
  assign outp      = outp_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Testbench for mux_arbiter: two instances (MAX_HOLD = 4 and MAX_HOLD = 1)
// share the same stimulus; a run-length based reference model predicts both.
module tb_mux_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_a = 1'b0;
  logic         req_b = 1'b0;
  logic [W-1:0] data_a = '0;
  logic [W-1:0] data_b = '0;

  logic [1:0]   d_gnt_a, d_gnt_b, d_sel, d_val;
  logic [W-1:0] d_outp [2];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: owner 0 none, 1 A, 2 B; run = cycles owned so far.
  int           m_own  [2];
  int           m_run  [2];
  int           m_last [2];
  logic         m_sel  [2];
  logic [W-1:0] m_outp [2];
  logic         m_val  [2];
  int           m_max  [2] = '{4, 1};

  always #5 clk = ~clk;

  mux_arbiter #(.WIDTH(W), .MAX_HOLD(4)) u_dut4 (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
    .data_a(data_a), .data_b(data_b),
    .gnt_a(d_gnt_a[0]), .gnt_b(d_gnt_b[0]), .sel(d_sel[0]),
    .outp(d_outp[0]), .out_valid(d_val[0])
  );

  mux_arbiter #(.WIDTH(W), .MAX_HOLD(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
    .data_a(data_a), .data_b(data_b),
    .gnt_a(d_gnt_a[1]), .gnt_b(d_gnt_b[1]), .sel(d_sel[1]),
    .outp(d_outp[1]), .out_valid(d_val[1])
  );

  function automatic void m_reset();
    for (int k = 0; k < 2; k++) begin
      m_own[k]  = 0;
      m_run[k]  = 0;
      m_last[k] = 2;
      m_sel[k]  = 1'b0;
      m_outp[k] = '0;
      m_val[k]  = 1'b0;
    end
  endfunction

  function automatic void m_step(int k);
    int nxt;
    m_val[k] = (m_own[k] == 1 && req_a) || (m_own[k] == 2 && req_b);
    if (m_val[k]) m_outp[k] = (m_own[k] == 1) ? data_a : data_b;
    nxt = m_own[k];
    if (m_own[k] == 0) begin
      if (req_a && req_b) nxt = (m_last[k] == 1) ? 2 : 1;
      else if (req_a)     nxt = 1;
      else if (req_b)     nxt = 2;
    end else begin
      // mine/other: request of the owner and of the waiting side
      logic mine, other;
      mine  = (m_own[k] == 1) ? req_a : req_b;
      other = (m_own[k] == 1) ? req_b : req_a;
      if (!mine)                               nxt = other ? 3 - m_own[k] : 0;
      else if (other && m_run[k] >= m_max[k])  nxt = 3 - m_own[k];
    end
    if (nxt != 0 && nxt != m_own[k]) begin
      m_run[k]  = 1;
      m_last[k] = nxt;
    end else if (nxt != 0 && m_run[k] < m_max[k]) begin
      m_run[k]++;
    end
    m_own[k] = nxt;
    if (nxt == 1) m_sel[k] = 1'b0;
    if (nxt == 2) m_sel[k] = 1'b1;
  endfunction

  // One rising edge; the model follows it and outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      m_step(0);
      m_step(1);
    end
    #1;
  endtask

  task automatic do_reset();
    req_a = 1'b0;
    req_b = 1'b0;
    rst   = 1'b1;
    m_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({d_gnt_a[k], d_gnt_b[k], d_sel[k], d_val[k], d_outp[k]} !== '0) begin
        n_errors++;
        $display("FAIL reset_state[%0d]: got ga=%b gb=%b sel=%b v=%b outp=%h, expected all zero",
                 k, d_gnt_a[k], d_gnt_b[k], d_sel[k], d_val[k], d_outp[k]);
      end
    end
    do_reset();
  endtask

  task automatic test_single();
    logic [W-1:0] vals [3] = '{8'h11, 8'h22, 8'h33};
    do_reset();
    req_a  = 1'b1;
    data_a = 8'h11;
    tick();
    n_checks++;
    if (d_gnt_a[0] !== 1'b1 || d_val[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL single_grant: got ga=%b v=%b, expected ga=1 v=0", d_gnt_a[0], d_val[0]);
    end
    for (int i = 0; i < 3; i++) begin
      data_a = vals[i];
      tick();
      n_checks++;
      if (d_outp[0] !== vals[i] || d_val[0] !== 1'b1) begin
        n_errors++;
        $display("FAIL single_data[%0d]: got outp=%h v=%b, expected outp=%h v=1",
                 i, d_outp[0], d_val[0], vals[i]);
      end
    end
    req_a = 1'b0;
    tick();
    n_checks++;
    if (d_gnt_a[0] !== 1'b0 || d_val[0] !== 1'b0 || d_outp[0] !== 8'h33) begin
      n_errors++;
      $display("FAIL single_release: got ga=%b v=%b outp=%h, expected ga=0 v=0 outp=33",
               d_gnt_a[0], d_val[0], d_outp[0]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_a = 1'b1;
    req_b = 1'b1;
    tick();
    n_checks++;
    if (d_gnt_a[0] !== 1'b1 || d_gnt_b[0] !== 1'b0 || d_sel[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL tie_first: got ga=%b gb=%b sel=%b, expected ga=1 gb=0 sel=0",
               d_gnt_a[0], d_gnt_b[0], d_sel[0]);
    end
    req_a = 1'b0;
    tick();
    n_checks++;
    if (d_gnt_a[0] !== 1'b0 || d_gnt_b[0] !== 1'b1 || d_sel[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL handover: got ga=%b gb=%b sel=%b, expected ga=0 gb=1 sel=1",
               d_gnt_a[0], d_gnt_b[0], d_sel[0]);
    end
    req_b = 1'b0;
    tick();
    n_checks++;
    if (d_gnt_b[0] !== 1'b0 || d_sel[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL idle_sel_hold: got gb=%b sel=%b, expected gb=0 sel=1", d_gnt_b[0], d_sel[0]);
    end
  endtask

  task automatic test_rotation();
    do_reset();
    req_a = 1'b1;
    req_b = 1'b1;
    for (int i = 0; i < 12; i++) begin
      logic exp_a;
      exp_a = ((i / 4) % 2) == 0;
      tick();
      n_checks++;
      if (d_gnt_a[0] !== exp_a || d_gnt_b[0] !== !exp_a) begin
        n_errors++;
        $display("FAIL rotation[%0d]: got ga=%b gb=%b, expected ga=%b gb=%b",
                 i, d_gnt_a[0], d_gnt_b[0], exp_a, !exp_a);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    req_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (d_gnt_a[0] !== 1'b1) begin
        n_errors++;
        $display("FAIL saturation_hold[%0d]: got ga=%b, expected 1", i, d_gnt_a[0]);
      end
    end
    req_b = 1'b1;
    tick();
    n_checks++;
    if (d_gnt_b[0] !== 1'b1 || d_gnt_a[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL saturation_switch: got ga=%b gb=%b, expected ga=0 gb=1", d_gnt_a[0], d_gnt_b[0]);
    end
  endtask

  task automatic test_max_hold_one();
    logic [W-1:0] da [12];
    logic [W-1:0] db [12];
    do_reset();
    req_a = 1'b1;
    req_b = 1'b1;
    for (int i = 0; i < 12; i++) begin
      da[i]  = W'($urandom);
      db[i]  = W'($urandom);
      data_a = da[i];
      data_b = db[i];
      tick();
      n_checks++;
      if (d_sel[1] !== 1'(i % 2)) begin
        n_errors++;
        $display("FAIL mh1_sel[%0d]: got %b, expected %b", i, d_sel[1], 1'(i % 2));
      end
      if (i > 0) begin
        logic [W-1:0] exp_d;
        exp_d = ((i - 1) % 2 == 0) ? da[i] : db[i];
        n_checks++;
        if (d_outp[1] !== exp_d || d_val[1] !== 1'b1) begin
          n_errors++;
          $display("FAIL mh1_data[%0d]: got outp=%h v=%b, expected outp=%h v=1",
                   i, d_outp[1], d_val[1], exp_d);
        end
      end
    end
  endtask

  task automatic test_reset_midgrant();
    do_reset();
    req_b  = 1'b1;
    data_b = 8'h5A;
    tick();
    tick();
    n_checks++;
    if (d_gnt_b[0] !== 1'b1 || d_outp[0] !== 8'h5A) begin
      n_errors++;
      $display("FAIL midgrant_setup: got gb=%b outp=%h, expected gb=1 outp=5a", d_gnt_b[0], d_outp[0]);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({d_gnt_a[0], d_gnt_b[0], d_sel[0], d_val[0], d_outp[0]} !== '0) begin
      n_errors++;
      $display("FAIL async_reset: got ga=%b gb=%b sel=%b v=%b outp=%h, expected all zero",
               d_gnt_a[0], d_gnt_b[0], d_sel[0], d_val[0], d_outp[0]);
    end
    m_reset();
    #2;
    rst   = 1'b0;
    req_a = 1'b1;
    tick();
    n_checks++;
    if (d_gnt_a[0] !== 1'b1 || d_gnt_b[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL post_reset_tie: got ga=%b gb=%b, expected ga=1 gb=0", d_gnt_a[0], d_gnt_b[0]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req_a  = ($urandom_range(0, 3) != 0);
      req_b  = ($urandom_range(0, 3) != 0);
      data_a = W'($urandom);
      data_b = W'($urandom);
      tick();
      for (int k = 0; k < 2; k++) begin
        logic eg_a, eg_b;
        eg_a = (m_own[k] == 1);
        eg_b = (m_own[k] == 2);
        n_checks++;
        if (d_gnt_a[k] !== eg_a || d_gnt_b[k] !== eg_b || d_sel[k] !== m_sel[k]) begin
          n_errors++;
          $display("FAIL random_grant[%0d/%0d]: got ga=%b gb=%b sel=%b, expected ga=%b gb=%b sel=%b",
                   k, i, d_gnt_a[k], d_gnt_b[k], d_sel[k], eg_a, eg_b, m_sel[k]);
        end
        n_checks++;
        if (d_val[k] !== m_val[k] || d_outp[k] !== m_outp[k]) begin
          n_errors++;
          $display("FAIL random_data[%0d/%0d]: got v=%b outp=%h, expected v=%b outp=%h",
                   k, i, d_val[k], d_outp[k], m_val[k], m_outp[k]);
        end
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_rotation();
    test_saturation();
    test_max_hold_one();
    test_reset_midgrant();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Two-requester round-robin arbiter that owns the select line of a shared 2:1 datapath mux. It grants one requester at a time, drives the mux select from the current grant, and registers the selected data word with a valid flag. A hold counter stops either requester from monopolising the mux while the other is waiting.

## Interface
- `WIDTH`, default 8: data word width.
- `MAX_HOLD`, default 4: maximum consecutive granted cycles while the other side is requesting. Legal range ≥ 1.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `req_a` input 1: request from requester A, level-sensitive.
- `req_b` input 1: request from requester B, level-sensitive.
- `data_a` input WIDTH: requester A data, mux input 0.
- `data_b` input WIDTH: requester B data, mux input 1.
- `gnt_a` output 1: A owns the mux (registered).
- `gnt_b` output 1: B owns the mux (registered).
- `sel` output 1: mux select. 0 selects `data_a`, 1 selects `data_b` (registered).
- `outp` output WIDTH: registered selected data.
- `out_valid` output 1: `outp` holds a word captured during a granted, still-requesting cycle.

## Operation
- States: IDLE, GRANT_A, GRANT_B. Internal state also holds `last` (last side granted) and `hold_cnt` (0..MAX_HOLD-1).
- Reset values: state IDLE, `gnt_a` 0, `gnt_b` 0, `sel` 0, `outp` 0, `out_valid` 0, `hold_cnt` 0, `last` = B, so A wins the first tie.
- IDLE:
  - Only `req_a` set → GRANT_A.
  - Only `req_b` set → GRANT_B.
  - Both set → grant the side opposite `last`.
  - Neither set → stay in IDLE.
- GRANT_A:
  - `req_a` low and `req_b` high → GRANT_B directly, with no idle bubble.
  - `req_a` low and `req_b` low → IDLE.
  - `req_a` and `req_b` both high with `hold_cnt == MAX_HOLD-1` → forced rotation to GRANT_B.
  - Otherwise stay in GRANT_A and increment `hold_cnt`. The counter saturates at MAX_HOLD-1 while B is not requesting.
- GRANT_B: mirror of GRANT_A.
- Any entry into a grant state clears `hold_cnt` to 0 and sets `last` to the newly granted side.
- `gnt_a = (state == GRANT_A)`, `gnt_b = (state == GRANT_B)`. Both are never high together.
- `sel` is 1 in GRANT_B and 0 in GRANT_A. In IDLE, `sel` holds its previous value.
- Data capture, every edge:
  - `out_valid <= (GRANT_A & req_a) | (GRANT_B & req_b)`.
  - When that term is 1, `outp <=` the data of the granted side. Otherwise `outp` holds its value.
- With MAX_HOLD = 1 and both sides requesting continuously, the grant alternates every cycle.

## Timing
- Request to grant: a request sampled high at edge N makes the grant visible after edge N (1 cycle).
- Grant to data: the first `outp`/`out_valid` is visible after edge N+1 (2 cycles from request).
- Release: `req_x` dropping before edge M moves the state out of GRANT_x after edge M. `out_valid` is 0 after edge M, because the data term uses the current request level.
- Handover: grant transfers in one edge, and no cycle has both grants high.
- Fairness: with both sides requesting continuously, each side gets exactly MAX_HOLD consecutive granted cycles before the switch.
- Simultaneous requests in IDLE are resolved by `last` only.
- Reset mid-grant: all outputs take their reset values immediately, with no clock needed. After `rst` deasserts, the first tie goes to A.

## Test plan
- **Reset:** assert `rst` asynchronously mid-GRANT_B with `outp` = 0x5A → immediately `gnt_a` = `gnt_b` = 0, `sel` = 0, `outp` = 0, `out_valid` = 0, without waiting for a clock edge.
- **Single requester:** `req_a` = 1 for 3 cycles, `data_a` = 0x11, 0x22, 0x33 → `gnt_a` high 1 cycle after the request. `outp` shows 0x11, 0x22, 0x33 with `out_valid` = 1, starting 2 cycles after the request.
- **Tie from IDLE after reset:** `req_a` = `req_b` = 1 on the same edge → GRANT_A, `sel` = 0. After `req_a` drops → GRANT_B on the next edge, `sel` = 1, no IDLE cycle.
- **Forced rotation, MAX_HOLD = 4:** both sides request continuously for 12 cycles → grant pattern A×4, B×4, A×4. `gnt_a` & `gnt_b` is never 1.
- **Saturation:** `req_a` held for 10 cycles with `req_b` = 0 → GRANT_A holds throughout. Then `req_b` rises → switch to B exactly 1 edge later, because `hold_cnt` is already saturated.
- **MAX_HOLD = 1:** both sides request continuously → `sel` toggles every cycle. `outp` alternates `data_a`/`data_b` with a 1-cycle lag.
